multicycle_core: RTL and testbench
==================================

MULTICYCLE_CORE -- requirements
Module: multicycle_core

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, range 16..32, width of the PC and memory addresses.
REQ-002 SHALL have parameter RESET_PC, default 0, fetch address after reset.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have ports imem_req/imem_addr/imem_ready/imem_rdata: out 1, out ADDR_W, in 1, in 32; instruction fetch handshake.
REQ-006 SHALL have ports dmem_req/dmem_we/dmem_addr/dmem_wdata/dmem_ready/dmem_rdata: out 1, out 1, out ADDR_W, out 32, in 1, in 32; data access handshake.
REQ-007 SHALL have ports pc_out (out ADDR_W, current PC), alu_result (out 32, registered ALU result), retire (out 1, one-cycle pulse per completed instruction) and halted (out 1, sticky illegal-instruction flag).

Function
REQ-008 SHALL be a multicycle FSM with states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-009 FETCH: imem_req=1 with imem_addr=PC; on imem_req&&imem_ready, SHALL latch imem_rdata into IR and go to DECODE; otherwise stay in FETCH.
REQ-010 DECODE: SHALL read rs/rt from the 32x32 register file and compute branch target PC+4+(sext(imm16)<<2), truncated to ADDR_W.
REQ-011 EXEC: SHALL drive the ALU and latch alu_result; R-type/addi go to WB; lw/sw go to MEM; beq/bne/j update PC, pulse retire, return to FETCH.
REQ-012 MEM: dmem_req=1, dmem_addr=alu_result[ADDR_W-1:0], dmem_we=1 for sw; lw goes to WB on ready; sw pulses retire and goes to FETCH on ready.
REQ-013 WB: SHALL write rd (R-type) or rt (addi, lw) with alu_result or latched dmem_rdata, PC+=4, pulse retire, go to FETCH.
REQ-014 Zero-wait latencies SHALL be: beq/bne/j 3 cycles, R-type/addi/sw 4, lw 5; each ready-low cycle adds one.
REQ-015 Supported: R-type (op 000000) funct add 100000, sub 100010, and 100100, or 100101, slt 101010 (signed); addi 001000; lw 100011; sw 101011; beq 000100; bne 000101; j 000010.
REQ-016 Arithmetic SHALL wrap modulo 2^32; no overflow trap; addi sign-extends imm16.
REQ-017 j target SHALL be {PC+4[31:28], imm26, 2'b00} truncated to ADDR_W; not-taken branch PC+=4.
REQ-018 Register 0 SHALL read as zero; writes to it SHALL be discarded.
REQ-019 Address/wdata/we SHALL stay stable while req is high until ready; req SHALL drop the cycle after the handshake.
REQ-020 Unrecognised opcode/funct in DECODE SHALL enter HALT: halted=1, no req, PC frozen, until reset.
REQ-021 Memory ready outside an active req SHALL be ignored.

Reset
REQ-022 On rst low, any state: FSM=FETCH, PC=RESET_PC, IR=0, alu_result=0, retire=0, halted=0, all req/we=0; an in-flight handshake is abandoned without register-file write.
REQ-023 Register file contents SHALL be cleared to zero by reset.
REQ-024 First imem_req SHALL assert in the first clk edge after rst deasserts.

Configuration
REQ-025 Macro CORE_SHIFT_EN: defined adds sll (funct 000000) and srl (funct 000010), shifting rt by shamt into rd; undefined treats both funct codes as illegal (HALT); the nop encoding 0x00000000 then halts.

Structure
REQ-026 Package core_pkg SHALL hold opcode/funct localparams, the FSM state enum and the ALU-op enum.
REQ-027 ALU SHALL be sub-module core_alu (combinational, ops add/sub/and/or/slt/sll/srl, shamt input); register file and FSM stay in multicycle_core.

Verification
REQ-028 addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2 with ready tied 1 -> r3=2, retire every 4 cycles, pc_out=12 after third retire.
REQ-029 sw r1,8(r0) then lw r4,8(r0), dmem_ready low 3 cycles each -> dmem_addr/wdata stable=8/5 throughout, r4=5, lw takes 8 cycles.
REQ-030 beq r0,r0,+2 at PC 0 -> next fetch 12; bne r0,r0,+2 -> next fetch 4; j 0x40 -> next fetch 0x100.
REQ-031 Fetch 0xFC000000 (opcode 111111) -> halted=1, imem_req=0 forever; rst pulse -> fetch from RESET_PC.
REQ-032 rst asserted mid-MEM of lw with dmem_ready low -> dmem_req=0 immediately, destination register unchanged (0), restart at RESET_PC.
REQ-033 CORE_SHIFT_EN defined: sll r5,r1,3 with r1=5 -> r5=40; undefined: same instruction -> halted=1.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: opcodes, funct codes, FSM states and ALU ops for the multicycle core
package core_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL} alu_op_t;
endpackage

// File: rtl/core_alu.sv
// core_alu: combinational ALU with wrapping arithmetic, signed slt and rt shifts by shamt
module core_alu import core_pkg::*; (
  input  alu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  output logic [31:0] y
);
  always_comb
    y = op == ALU_SUB ? a - b
      : op == ALU_AND ? a & b
      : op == ALU_OR  ? a | b
      : op == ALU_SLT ? {31'd0, $signed(a) < $signed(b)}
      : op == ALU_SLL ? b << shamt
      : op == ALU_SRL ? b >> shamt
      : a + b;
endmodule

// File: rtl/multicycle_core.sv
// multicycle_core: FETCH/DECODE/EXEC/MEM/WB MIPS-subset core with illegal-instruction HALT
// define CORE_SHIFT_EN to decode sll/srl; otherwise those funct codes (and the nop) halt
module multicycle_core import core_pkg::*; #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ready,
  input  logic [31:0]       dmem_rdata,
  output logic [ADDR_W-1:0] pc_out,
  output logic [31:0]       alu_result,
  output logic              retire,
  output logic              halted
);
`ifdef CORE_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif
  state_t state, state_n;
  alu_op_t alu_op;
  logic [31:0] ir, a_q, b_q, mdr, simm, alu_b, alu_y, pc4_w;
  logic [31:0] regs [32];
  logic [ADDR_W-1:0] pc, tgt, pc4, jtgt;
  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd, sh, wa;
  logic is_r, is_br, is_mem, legal, taken;
  assign op = ir[31:26];
  assign rs = ir[25:21];
  assign rt = ir[20:16];
  assign rd = ir[15:11];
  assign sh = ir[10:6];
  assign fn = ir[5:0];
  assign simm = {{16{ir[15]}}, ir[15:0]};
  assign is_r = op == OP_RTYPE;
  assign is_br = op inside {OP_BEQ, OP_BNE, OP_J};
  assign is_mem = op inside {OP_LW, OP_SW};
  assign wa = is_r ? rd : rt;
  assign pc4_w = 32'(pc) + 32'd4;
  assign pc4 = ADDR_W'(pc4_w);
  assign jtgt = ADDR_W'({pc4_w[31:28], ir[25:0], 2'b00});
  assign taken = op == OP_BEQ ? a_q == b_q : a_q != b_q;
  assign legal = is_r ? (fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT} || (SHIFT_EN && fn inside {FN_SLL, FN_SRL}))
                      : op inside {OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J};
  assign alu_op = !is_r ? ALU_ADD
                : fn == FN_SUB ? ALU_SUB
                : fn == FN_AND ? ALU_AND
                : fn == FN_OR  ? ALU_OR
                : fn == FN_SLT ? ALU_SLT
                : fn == FN_SLL ? ALU_SLL
                : fn == FN_SRL ? ALU_SRL
                : ALU_ADD;
  assign alu_b = is_r ? b_q : simm;
  core_alu u_alu (.op(alu_op), .a(a_q), .b(alu_b), .shamt(sh), .y(alu_y));
  // Handshake outputs come straight from state and registers, so they hold steady until ready
  assign imem_req = state == FETCH;
  assign imem_addr = pc;
  assign dmem_req = state == MEM;
  assign dmem_we = state == MEM && op == OP_SW;
  assign dmem_addr = alu_result[ADDR_W-1:0];
  assign dmem_wdata = b_q;
  assign pc_out = pc;
  assign halted = state == HALT;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= FETCH;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      FETCH:   state_n = imem_ready ? DECODE : FETCH;
      DECODE:  state_n = legal ? EXEC : HALT;
      EXEC:    state_n = is_mem ? MEM : is_br ? FETCH : WB;
      MEM:     state_n = !dmem_ready ? MEM : op == OP_LW ? WB : FETCH;
      WB:      state_n = FETCH;
      default: state_n = state;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
      ir <= '0;
      a_q <= '0;
      b_q <= '0;
      mdr <= '0;
      tgt <= '0;
      alu_result <= '0;
      retire <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      retire <= 1'b0;
      case (state)
        FETCH: if (imem_ready) ir <= imem_rdata;
        DECODE: begin
          a_q <= regs[rs];
          b_q <= regs[rt];
          tgt <= pc4 + ADDR_W'({simm[29:0], 2'b00});
        end
        EXEC: begin
          alu_result <= alu_y;
          if (is_br) begin
            pc <= op == OP_J ? jtgt : taken ? tgt : pc4;
            retire <= 1'b1;
          end
        end
        MEM: if (dmem_ready) begin
          mdr <= dmem_rdata;
          if (op == OP_SW) begin
            pc <= pc4;
            retire <= 1'b1;
          end
        end
        WB: begin
          if (wa != 5'd0) regs[wa] <= op == OP_LW ? mdr : alu_result;
          pc <= pc4;
          retire <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_core.sv
// tb_multicycle_core: directed programs with hand-computed results for multicycle_core
module tb_multicycle_core;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, retire, halted;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, pc_out, alu_result;
  logic [31:0] imem [64];
  logic [31:0] dmem [16] = '{default: 32'd0};
  int imem_wait = 0, dmem_wait = 0, icnt = 0, dcnt = 0;
  int n_checks = 0, n_fail = 0;
  logic mon_en = 1'b0;
  int sw_cyc = 0, lw_cyc = 0, bad = 0;

  multicycle_core #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .pc_out(pc_out), .alu_result(alu_result), .retire(retire), .halted(halted)
  );

  always #5 clk = ~clk;

  assign imem_rdata = imem[imem_addr[7:2]];
  assign dmem_rdata = dmem[dmem_addr[5:2]];
  assign imem_ready = icnt >= imem_wait;
  assign dmem_ready = dcnt >= dmem_wait;

  always @(posedge clk) begin
    icnt <= (imem_req && rst) ? icnt + 1 : 0;
    dcnt <= (dmem_req && rst) ? dcnt + 1 : 0;
    if (dmem_req && dmem_we && dmem_ready) dmem[dmem_addr[5:2]] <= dmem_wdata;
  end

  always @(negedge clk)
    if (mon_en && dmem_req) begin
      if (dmem_we) sw_cyc++;
      else lw_cyc++;
      if (dmem_addr != 32'd8 || (dmem_we && dmem_wdata != 32'd5)) bad++;
    end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_imem();
    foreach (imem[i]) imem[i] = 32'h1000FFFF;
  endtask

  task automatic restart();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_retire(input string tag, input int exp);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!retire && n < 40);
    check(tag, n, exp);
  endtask

  logic [31:0] br_ins [3] = '{32'h10000002, 32'h14000002, 32'h08000040};
  logic [31:0] br_pc  [3] = '{32'd12, 32'd4, 32'h100};

  initial begin
    clear_imem();
    imem[0] = 32'h20010005;
    imem[1] = 32'h2002FFFD;
    imem[2] = 32'h00221820;
    imem[3] = 32'h00223022;
    imem[4] = 32'h00223824;
    imem[5] = 32'h00224025;
    imem[6] = 32'h0041482A;
    imem[7] = 32'h0022502A;
    imem[8] = 32'h00210020;
    repeat (2) @(negedge clk);
    check("rst_pc", pc_out, 32'd0);
    check("rst_alu", alu_result, 32'd0);
    check("rst_retire", {31'd0, retire}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_dmem_req", {30'd0, dmem_req, dmem_we}, 32'd0);
    rst = 1'b1;
    check("first_fetch", {31'd0, imem_req}, 32'd1);
    wait_retire("addi1_cyc", 4);
    wait_retire("addi2_cyc", 4);
    wait_retire("add_cyc", 4);
    check("pc_after3", pc_out, 32'd12);
    check("r3", dut.regs[3], 32'd2);
    for (int i = 0; i < 6; i++) wait_retire("rtype_cyc", 4);
    check("sub_r6", dut.regs[6], 32'd8);
    check("and_r7", dut.regs[7], 32'd5);
    check("or_r8", dut.regs[8], 32'hFFFFFFFD);
    check("slt_r9", dut.regs[9], 32'd1);
    check("slt_r10", dut.regs[10], 32'd0);
    check("r0_zero", dut.regs[0], 32'd0);
    check("alu_r0_write", alu_result, 32'd10);
    check("pc_after9", pc_out, 32'd36);

    clear_imem();
    imem[0] = 32'h20010005;
    imem_wait = 2;
    restart();
    wait_retire("fetch_wait_cyc", 6);
    imem_wait = 0;

    clear_imem();
    imem[0] = 32'h20010005;
    imem[1] = 32'hAC010008;
    imem[2] = 32'h8C040008;
    dmem_wait = 3;
    mon_en = 1'b1;
    restart();
    wait_retire("mem_addi_cyc", 4);
    wait_retire("sw_cyc", 7);
    wait_retire("lw_cyc", 8);
    mon_en = 1'b0;
    check("lw_r4", dut.regs[4], 32'd5);
    check("dmem_word", dmem[2], 32'd5);
    check("mem_stable", bad, 32'd0);
    check("sw_req_cycles", sw_cyc, 32'd4);
    check("lw_req_cycles", lw_cyc, 32'd4);
    dmem_wait = 0;

    for (int i = 0; i < 3; i++) begin
      clear_imem();
      imem[0] = br_ins[i];
      restart();
      wait_retire("branch_cyc", 3);
      check("branch_pc", pc_out, br_pc[i]);
      check("branch_fetch", imem_addr, br_pc[i]);
    end

    clear_imem();
    imem[0] = 32'hFC000000;
    restart();
    repeat (10) @(negedge clk);
    check("halt_flag", {31'd0, halted}, 32'd1);
    check("halt_noreq", {31'd0, imem_req}, 32'd0);
    check("halt_pc", pc_out, 32'd0);
    imem[0] = 32'h20010005;
    restart();
    check("unhalt", {30'd0, halted, imem_req}, 32'd1);
    wait_retire("post_halt_cyc", 4);

    clear_imem();
    imem[0] = 32'h20010005;
    imem[1] = 32'h8C040008;
    dmem_wait = 100;
    restart();
    wait_retire("pre_lw_cyc", 4);
    begin
      int k;
      k = 0;
      while (!dmem_req && k < 10) begin
        @(negedge clk);
        k++;
      end
    end
    check("lw_in_mem", {31'd0, dmem_req}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_req", {31'd0, dmem_req}, 32'd0);
    check("abort_r4", dut.regs[4], 32'd0);
    check("abort_r1", dut.regs[1], 32'd0);
    check("abort_pc", pc_out, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    check("abort_refetch", {31'd0, imem_req}, 32'd1);
    dmem_wait = 0;

    clear_imem();
    imem[0] = 32'h20010005;
    imem[1] = 32'h000128C0;
    restart();
    wait_retire("sll_pre_cyc", 4);
`ifdef CORE_SHIFT_EN
    wait_retire("sll_cyc", 4);
    check("sll_r5", dut.regs[5], 32'd40);
`else
    repeat (4) @(negedge clk);
    check("sll_halt", {31'd0, halted}, 32'd1);
    check("sll_noreq", {31'd0, imem_req}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
